// File: rtl/ets_capture_if.sv
// Readout stream bundle for ets_capture: one 12-bit sample per beat,
// tagged with its point index and a last-beat flag.
interface ets_capture_if;
    logic [11:0] m_data;
    logic [7:0]  m_index;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;

    modport master (output m_data, output m_index, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_index, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/ets_capture.sv
// Equivalent-time capture: stores 256 strobed ADC words, then streams them out in index order.
// Optional saturating drop counter is enabled by defining ETS_CAPTURE_DROP_CNT_EN.
module ets_capture (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sp_en,
    input  logic [11:0]   adc_data,
    ets_capture_if.master m_bus,
    output logic          cap_busy,
    output logic          drop
`ifdef ETS_CAPTURE_DROP_CNT_EN
    ,
    output logic [15:0]   drop_cnt
`endif
);

    typedef enum logic [0:0] {
        ST_CAPTURE = 1'b0,
        ST_READOUT = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  wr_ptr_q, wr_ptr_d;
    logic [7:0]  rd_ptr_q, rd_ptr_d;
    logic [7:0]  m_index_q, m_index_d;
    logic        m_valid_q, m_valid_d;
    logic        m_last_q, m_last_d;
    logic        cap_busy_q, cap_busy_d;
    logic        drop_q, drop_d;
    logic [11:0] m_data_q;
    logic [11:0] ram_q [0:255];
    logic        wr_en_s;
    logic        rd_en_s;
    logic        xfer_s;

    // Next-state, pointer and output-slot control for both phases.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        m_index_d = m_index_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        wr_en_s   = 1'b0;
        rd_en_s   = 1'b0;
        drop_d    = 1'b0;
        xfer_s    = m_valid_q & m_bus.m_ready;
        case (state_q)
            ST_CAPTURE: begin
                rd_ptr_d  = 8'd0;
                m_valid_d = 1'b0;
                m_last_d  = 1'b0;
                if (sp_en) begin
                    wr_en_s  = 1'b1;
                    wr_ptr_d = wr_ptr_q + 8'd1;
                    if (wr_ptr_q == 8'd255) begin
                        state_d = ST_READOUT;
                    end else begin
                        state_d = ST_CAPTURE;
                    end
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            ST_READOUT: begin
                drop_d = sp_en;
                // The output register doubles as the RAM read register: refill it
                // whenever it is empty or being drained, so there are no bubbles.
                if (xfer_s && m_last_q) begin
                    state_d   = ST_CAPTURE;
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                end else if (!m_valid_q || m_bus.m_ready) begin
                    rd_en_s   = 1'b1;
                    m_index_d = rd_ptr_q;
                    m_last_d  = (rd_ptr_q == 8'd255);
                    m_valid_d = 1'b1;
                    rd_ptr_d  = rd_ptr_q + 8'd1;
                end else begin
                    rd_en_s = 1'b0;
                end
            end
            default: begin
                state_d   = ST_CAPTURE;
                m_valid_d = 1'b0;
                m_last_d  = 1'b0;
            end
        endcase
        cap_busy_d = (state_d == ST_CAPTURE) && (wr_ptr_d != 8'd0);
    end

    // Control and output-slot registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_CAPTURE;
            wr_ptr_q   <= 8'd0;
            rd_ptr_q   <= 8'd0;
            m_index_q  <= 8'd0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            cap_busy_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            m_index_q  <= m_index_d;
            m_valid_q  <= m_valid_d;
            m_last_q   <= m_last_d;
            cap_busy_q <= cap_busy_d;
            drop_q     <= drop_d;
        end
    end

    // Sample buffer write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            ram_q[wr_ptr_q] <= adc_data;
        end
    end

    // Registered read port with enable and synchronous reset on the output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_data_q <= 12'd0;
        end else if (rd_en_s) begin
            m_data_q <= ram_q[rd_ptr_q];
        end
    end

`ifdef ETS_CAPTURE_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Saturating count of discarded strobes.
    always_comb begin
        if (drop_d && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt_q <= 16'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    assign m_bus.m_data  = m_data_q;
    assign m_bus.m_index = m_index_q;
    assign m_bus.m_valid = m_valid_q;
    assign m_bus.m_last  = m_last_q;
    assign cap_busy      = cap_busy_q;
    assign drop          = drop_q;

endmodule

// File: doc/ets_capture.md
ETS_CAPTURE -- requirements
Module: ets_capture

Interface
REQ-001 SHALL have input clk, 1 bit, 200 MHz system clock.
REQ-002 SHALL have input rst_n, 1 bit, synchronous, active-low reset.
REQ-003 SHALL have input sp_en, 1 bit, single-cycle sample strobe from the equivalent-time sampler.
REQ-004 SHALL have input adc_data, 12 bits, ADC word, valid in any cycle where sp_en=1.
REQ-005 SHALL have output m_data, 12 bits, readout sample.
REQ-006 SHALL have output m_index, 8 bits, point index of m_data (0..255).
REQ-007 SHALL have output m_valid, 1 bit, readout beat valid.
REQ-008 SHALL have input m_ready, 1 bit, downstream accept.
REQ-009 SHALL have output m_last, 1 bit, high with m_valid on index 255.
REQ-010 SHALL have output cap_busy, 1 bit, high in CAPTURE with at least one point stored.
REQ-011 SHALL have output drop, 1 bit, one-cycle pulse when an sp_en strobe is discarded.

Function
REQ-012 SHALL implement two states: CAPTURE (entered on reset) and READOUT.
REQ-013 SHALL hold an internal 256 x 12 sample buffer and an 8-bit write pointer wr_ptr.
REQ-014 In CAPTURE, each sp_en=1 cycle SHALL write adc_data to buffer[wr_ptr] and increment wr_ptr, with 8-bit wrap.
REQ-015 The strobe that writes index 255 SHALL move the state to READOUT on the next edge, with wr_ptr wrapped to 0.
REQ-016 In READOUT, the first m_valid SHALL assert exactly 2 cycles after the cycle of the index-255 strobe.
REQ-017 Readout SHALL present indices 0..255 in ascending order, with m_index equal to the buffer address.
REQ-018 A beat SHALL transfer only when m_valid=1 and m_ready=1.
REQ-019 m_data, m_index and m_last SHALL be held stable while m_valid=1 and m_ready=0.
REQ-020 With m_ready held high, readout SHALL sustain one beat per cycle with no bubbles (256 consecutive beats).
REQ-021 The transfer of the m_last beat SHALL return the state to CAPTURE on the next edge; m_valid SHALL be 0 in that next cycle.
REQ-022 Any sp_en=1 in READOUT, including the cycle of the m_last transfer, SHALL NOT be written and SHALL pulse drop for one cycle.
REQ-023 sp_en in CAPTURE SHALL never be dropped, including back-to-back strobes in consecutive cycles.
REQ-024 The buffer read path SHALL be a registered (synchronous) read, inferable as block RAM.

Reset
REQ-025 While rst_n=0 at a clk edge: state=CAPTURE, wr_ptr=0, m_valid=0, m_last=0, m_index=0, m_data=0, cap_busy=0, drop=0.
REQ-026 Reset SHALL abort a partial capture or readout; stored buffer contents need not be cleared.
REQ-027 After rst_n returns high, the first sp_en SHALL be stored at index 0.

Configuration
REQ-028 Macro ETS_CAPTURE_DROP_CNT_EN, when defined, SHALL add output drop_cnt (16 bits).
REQ-029 drop_cnt SHALL increment on each drop pulse, saturate at 0xFFFF, and reset to 0.
REQ-030 When ETS_CAPTURE_DROP_CNT_EN is undefined, the drop_cnt port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-031 Ramp test: reset, 256 sp_en strobes spaced 200..455 cycles with adc_data=index; m_ready=1 -> 256 beats with m_data=m_index=0..255, m_last only on 255, first m_valid 2 cycles after strobe 255.
REQ-032 Back-to-back test: 256 sp_en strobes in consecutive cycles with adc_data=0xFFF-index -> all captured, zero drop pulses, readout m_data=0xFFF-index.
REQ-033 Backpressure test: m_ready toggles 1,0,0,1 repeating during readout -> beats still ordered 0..255, outputs stable while stalled, no duplicate or missing index.
REQ-034 Drop test: 3 sp_en strobes during READOUT plus 1 in the m_last transfer cycle -> 4 drop pulses, drop_cnt=4 when the macro is defined; the next frame starts at index 0.
REQ-035 Mid-operation reset: rst_n=0 for 1 cycle after 100 strobes, then 256 new strobes -> readout shows only new-frame data for indices 0..255.
REQ-036 Build both with and without ETS_CAPTURE_DROP_CNT_EN -> REQ-031..REQ-035 pass in both builds; drop_cnt saturates at 0xFFFF under forced 65540 drops.
